// File: rtl/l1d_cache_ctrl_sa.sv
`default_nettype none
// ----------------------------------------------------------------------------
// l1d_cache_ctrl_sa: set-associative write-back/write-allocate L1D controller
// Revision: 1.0
// ----------------------------------------------------------------------------
module l1d_cache_ctrl_sa #(
  parameter int NUM_SETS    = 16,
  parameter int NUM_WAYS    = 2,
  parameter int BLOCK_BYTES = 16,
  parameter int ROB_ENTRIES = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           flush_i,
  input  logic                           lsu_req_vld_i,
  output logic                           lsu_req_rdy_o,
  input  logic                           lsu_req_wr_rd_i,
  input  logic [31:0]                    lsu_req_addr_i,
  input  logic [31:0]                    lsu_req_data_i,
  input  logic [$clog2(ROB_ENTRIES)-1:0] lsu_req_rob_idx_i,
  output logic                           cmt_vld_o,
  output logic                           cmt_is_store_o,
  output logic [31:0]                    cmt_ld_data_o,
  output logic [$clog2(ROB_ENTRIES)-1:0] cmt_rob_idx_o,
  output logic                           mem_req_vld_o,
  input  logic                           mem_req_rdy_i,
  output logic                           mem_req_we_o,
  output logic [31:0]                    mem_req_addr_o,
  output logic [8*BLOCK_BYTES-1:0]       mem_req_data_o,
  input  logic                           mem_resp_vld_i,
  input  logic [8*BLOCK_BYTES-1:0]       mem_resp_data_i,
  output logic [31:0]                    hit_cnt_o,
  output logic [31:0]                    miss_cnt_o
);

  localparam int OFF   = $clog2(BLOCK_BYTES);
  localparam int IDX   = $clog2(NUM_SETS);
  localparam int TAGW  = 32 - OFF - IDX;
  localparam int LINEW = 8 * BLOCK_BYTES;
  localparam int ROBW  = $clog2(ROB_ENTRIES);
  localparam int WAYW  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int WSELW = (OFF > 2) ? OFF - 2 : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOOKUP    = 3'd1,
    S_WB        = 3'd2,
    S_FILL_REQ  = 3'd3,
    S_FILL_WAIT = 3'd4,
    S_RESPOND   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic              req_wr_q, req_wr_d;
  logic [31:0]       req_addr_q, req_addr_d;
  logic [31:0]       req_data_q, req_data_d;
  logic [ROBW-1:0]   req_rob_q, req_rob_d;
  logic              squash_q, squash_d;
  logic [WAYW-1:0]   victim_q, victim_d;
  logic [31:0]       hit_cnt_q, hit_cnt_d;
  logic [31:0]       miss_cnt_q, miss_cnt_d;

  logic [TAGW-1:0]     tag_q   [NUM_SETS][NUM_WAYS];
  logic [LINEW-1:0]    data_q  [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
  logic [WAYW-1:0]     rr_q    [NUM_SETS];

  logic [TAGW-1:0]  req_tag;
  logic [IDX-1:0]   req_idx;
  logic [WSELW-1:0] req_wsel;
  logic             unused_addr_lsb;

  assign req_tag         = req_addr_q[31 -: TAGW];
  assign req_idx         = req_addr_q[OFF +: IDX];
  assign unused_addr_lsb = ^req_addr_q[1:0];

  generate
    if (OFF > 2) begin : g_wsel
      assign req_wsel = req_addr_q[2 +: WSELW];
    end else begin : g_wsel_single
      assign req_wsel = '0;
    end
  endgenerate

  function automatic logic [LINEW-1:0] merge_word(input logic [LINEW-1:0] line,
                                                  input logic [WSELW-1:0] sel,
                                                  input logic [31:0]      word);
    logic [LINEW-1:0] r;
    r = line;
    r[{sel, 5'b0} +: 32] = word;
    return r;
  endfunction

  function automatic logic [31:0] pick_word(input logic [LINEW-1:0] line,
                                            input logic [WSELW-1:0] sel);
    return line[{sel, 5'b0} +: 32];
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Tag match plus victim choice: lowest invalid way, else the set's round-robin way.
  logic            hit;
  logic [WAYW-1:0] hit_way;
  logic            inv_found;
  logic [WAYW-1:0] inv_way;
  logic [WAYW-1:0] miss_victim;

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAYW'(w);
      end
      if (!valid_q[req_idx][w] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WAYW'(w);
      end
    end
    miss_victim = inv_found ? inv_way : rr_q[req_idx];
  end

  logic             hitst_we;
  logic             fill_we;
  logic             fill_dirty;
  logic [WAYW-1:0]  wr_way;
  logic [LINEW-1:0] line_d;
  logic             sq_now;

  always_comb begin
    state_d        = state_q;
    req_wr_d       = req_wr_q;
    req_addr_d     = req_addr_q;
    req_data_d     = req_data_q;
    req_rob_d      = req_rob_q;
    squash_d       = squash_q;
    victim_d       = victim_q;
    hit_cnt_d      = hit_cnt_q;
    miss_cnt_d     = miss_cnt_q;
    lsu_req_rdy_o  = rst_i && (state_q == S_IDLE) && !flush_i;
    cmt_vld_o      = 1'b0;
    cmt_is_store_o = 1'b0;
    cmt_ld_data_o  = '0;
    cmt_rob_idx_o  = '0;
    mem_req_vld_o  = 1'b0;
    mem_req_we_o   = 1'b0;
    mem_req_addr_o = '0;
    mem_req_data_o = '0;
    hitst_we       = 1'b0;
    fill_we        = 1'b0;
    fill_dirty     = 1'b0;
    wr_way         = victim_q;
    line_d         = mem_resp_data_i;
    sq_now         = squash_q || flush_i;

    if ((state_q != S_IDLE) && flush_i) squash_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (lsu_req_vld_i && lsu_req_rdy_o) begin
          req_wr_d   = lsu_req_wr_rd_i;
          req_addr_d = lsu_req_addr_i;
          req_data_d = lsu_req_data_i;
          req_rob_d  = lsu_req_rob_idx_i;
          squash_d   = 1'b0;
          state_d    = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          hit_cnt_d = sat_inc(hit_cnt_q);
          if (!sq_now) begin
            cmt_vld_o      = 1'b1;
            cmt_is_store_o = req_wr_q;
            cmt_rob_idx_o  = req_rob_q;
            cmt_ld_data_o  = req_wr_q ? 32'd0 : pick_word(data_q[req_idx][hit_way], req_wsel);
            if (req_wr_q) begin
              hitst_we = 1'b1;
              wr_way   = hit_way;
              line_d   = merge_word(data_q[req_idx][hit_way], req_wsel, req_data_q);
            end
          end
          state_d = S_IDLE;
        end else begin
          miss_cnt_d = sat_inc(miss_cnt_q);
          victim_d   = miss_victim;
          state_d    = (valid_q[req_idx][miss_victim] && dirty_q[req_idx][miss_victim])
                       ? S_WB : S_FILL_REQ;
        end
      end
      S_WB: begin
        mem_req_vld_o  = 1'b1;
        mem_req_we_o   = 1'b1;
        mem_req_addr_o = {tag_q[req_idx][victim_q], req_idx, {OFF{1'b0}}};
        mem_req_data_o = data_q[req_idx][victim_q];
        if (mem_req_rdy_i) state_d = S_FILL_REQ;
      end
      S_FILL_REQ: begin
        mem_req_vld_o  = 1'b1;
        mem_req_addr_o = {req_addr_q[31:OFF], {OFF{1'b0}}};
        if (mem_req_rdy_i) state_d = S_FILL_WAIT;
      end
      S_FILL_WAIT: begin
        if (mem_resp_vld_i) begin
          fill_we    = 1'b1;
          fill_dirty = req_wr_q && !sq_now;
          line_d     = fill_dirty ? merge_word(mem_resp_data_i, req_wsel, req_data_q)
                                  : mem_resp_data_i;
          state_d    = S_RESPOND;
        end
      end
      S_RESPOND: begin
        if (!sq_now) begin
          cmt_vld_o      = 1'b1;
          cmt_is_store_o = req_wr_q;
          cmt_rob_idx_o  = req_rob_q;
          cmt_ld_data_o  = req_wr_q ? 32'd0 : pick_word(data_q[req_idx][victim_q], req_wsel);
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      req_wr_q   <= 1'b0;
      req_addr_q <= '0;
      req_data_q <= '0;
      req_rob_q  <= '0;
      squash_q   <= 1'b0;
      victim_q   <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      state_q    <= state_d;
      req_wr_q   <= req_wr_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
      req_rob_q  <= req_rob_d;
      squash_q   <= squash_d;
      victim_q   <= victim_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      if (hitst_we) dirty_q[req_idx][wr_way] <= 1'b1;
      if (fill_we) begin
        valid_q[req_idx][wr_way] <= 1'b1;
        dirty_q[req_idx][wr_way] <= fill_dirty;
        // Pointer only moves when the slot it names gets consumed.
        if (wr_way == rr_q[req_idx])
          rr_q[req_idx] <= (NUM_WAYS > 1) ? rr_q[req_idx] + 1'b1 : '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (hitst_we || fill_we) data_q[req_idx][wr_way] <= line_d;
    if (fill_we) tag_q[req_idx][wr_way] <= req_tag;
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_l1d_cache_ctrl_sa.sv
`default_nettype none
// tb_l1d_cache_ctrl_sa: directed scoreboard bench with a behavioural memory responder
module tb_l1d_cache_ctrl_sa;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         main_rst_n, mem_rst_n, main_flush, mem_flush;
  logic         rst_i, flush_i;
  logic         lsu_req_vld, lsu_req_rdy, lsu_wr;
  logic [31:0]  lsu_addr, lsu_data;
  logic [4:0]   lsu_rob;
  logic         cmt_vld_o, cmt_is_store_o;
  logic [31:0]  cmt_ld_data_o;
  logic [4:0]   cmt_rob_idx_o;
  logic         mem_req_vld_o, mem_rdy, mem_req_we_o;
  logic [31:0]  mem_req_addr_o;
  logic [127:0] mem_req_data_o;
  logic         mem_resp_vld;
  logic [127:0] mem_resp_data;
  logic [31:0]  hit_cnt_o, miss_cnt_o;

  assign rst_i   = main_rst_n & mem_rst_n;
  assign flush_i = main_flush | mem_flush;

  l1d_cache_ctrl_sa #(.NUM_SETS(16), .NUM_WAYS(2), .BLOCK_BYTES(16), .ROB_ENTRIES(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .lsu_req_vld_i(lsu_req_vld), .lsu_req_rdy_o(lsu_req_rdy), .lsu_req_wr_rd_i(lsu_wr),
    .lsu_req_addr_i(lsu_addr), .lsu_req_data_i(lsu_data), .lsu_req_rob_idx_i(lsu_rob),
    .cmt_vld_o(cmt_vld_o), .cmt_is_store_o(cmt_is_store_o), .cmt_ld_data_o(cmt_ld_data_o),
    .cmt_rob_idx_o(cmt_rob_idx_o),
    .mem_req_vld_o(mem_req_vld_o), .mem_req_rdy_i(mem_rdy), .mem_req_we_o(mem_req_we_o),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_data_o(mem_req_data_o),
    .mem_resp_vld_i(mem_resp_vld), .mem_resp_data_i(mem_resp_data),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  typedef struct { bit st; logic [31:0] data; logic [4:0] rob; int cyc; } cmt_t;
  typedef struct { bit we; logic [31:0] addr; bit chk; logic [127:0] blk; } mreq_t;

  cmt_t         sb[$];
  mreq_t        mq[$];
  logic [127:0] mem_model [logic [31:0]];
  int           checks = 0;
  int           passed = 0;
  int           cyc = 0;
  int           stall_cycles;
  bit           flush_in_wait, rst_in_wait, rst_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  function automatic logic [127:0] blk(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {a + 32'd3, a + 32'd2, a + 32'd1, a};
  endfunction

  // Completion monitor
  initial begin
    cmt_t e;
    forever begin
      @(negedge clk);
      if (cmt_vld_o) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_cmt: got rob %0d data %0h, required no completion",
                   cmt_rob_idx_o, cmt_ld_data_o);
        end else begin
          e = sb.pop_front();
          chk("cmt_is_store", cmt_is_store_o, e.st);
          chk("cmt_data", cmt_ld_data_o, e.data);
          chk("cmt_rob", cmt_rob_idx_o, e.rob);
          if (e.cyc != 0) chk("cmt_latency_cycle", cyc, e.cyc);
        end
      end else if ({cmt_is_store_o, cmt_ld_data_o, cmt_rob_idx_o} != '0) begin
        checks++;
        $display("FAIL cmt_idle_zero: got %0h required 0", {cmt_is_store_o, cmt_ld_data_o, cmt_rob_idx_o});
      end
    end
  end

  // Memory responder
  initial begin
    mreq_t        m;
    logic         we_s;
    logic [31:0]  addr_s;
    logic [127:0] data_s;
    mem_rdy = 1'b0; mem_resp_vld = 1'b0; mem_resp_data = '0; mem_flush = 1'b0; mem_rst_n = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_i && mem_req_vld_o) begin
        we_s = mem_req_we_o; addr_s = mem_req_addr_o; data_s = mem_req_data_o;
        for (int s = 0; s < stall_cycles; s++) begin
          @(negedge clk);
          chk("stall_ctrl_stable", {mem_req_vld_o, mem_req_we_o, mem_req_addr_o, lsu_req_rdy, cmt_vld_o},
              {1'b1, we_s, addr_s, 1'b0, 1'b0});
          chk("stall_data_stable", mem_req_data_o, data_s);
        end
        if (mq.size() == 0) begin
          checks++;
          $display("FAIL unexpected_mem_req: got we %0b addr %h, required none", we_s, addr_s);
        end else begin
          m = mq.pop_front();
          chk("mem_we", we_s, m.we);
          chk("mem_addr", addr_s, m.addr);
          if (m.chk) chk("wb_block", data_s, m.blk);
        end
        mem_rdy = 1'b1;
        @(negedge clk);
        mem_rdy = 1'b0;
        if (we_s) mem_model[addr_s] = data_s;
        else begin
          if (flush_in_wait) begin
            mem_flush = 1'b1; @(negedge clk); mem_flush = 1'b0;
          end
          if (rst_in_wait) begin
            mem_rst_n = 1'b0;
            #1;
            chk("rst_ctrl_zero", {cmt_vld_o, cmt_is_store_o, cmt_rob_idx_o, mem_req_vld_o, mem_req_we_o, lsu_req_rdy}, '0);
            chk("rst_word_zero", {cmt_ld_data_o, mem_req_addr_o, hit_cnt_o, miss_cnt_o}, '0);
            chk("rst_mem_data_zero", mem_req_data_o, '0);
            @(negedge clk); mem_rst_n = 1'b1;
            @(negedge clk); mem_resp_vld = 1'b1; mem_resp_data = {4{32'hBAD0_BAD0}};
            @(negedge clk); mem_resp_vld = 1'b0; rst_done = 1'b1;
          end else begin
            @(negedge clk); mem_resp_vld = 1'b1; mem_resp_data = blk(addr_s);
            @(negedge clk); mem_resp_vld = 1'b0;
          end
        end
      end
    end
  end

  task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [4:0] rob, input bit push, input logic [31:0] exp_data, input bit hit);
    int n = 0;
    @(negedge clk);
    while (!lsu_req_rdy && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) begin checks++; $display("FAIL issue_timeout: rdy got 0 required 1"); end
    if (push) sb.push_back('{wr, exp_data, rob, hit ? cyc + 1 : 0});
    lsu_req_vld = 1'b1; lsu_wr = wr; lsu_addr = addr; lsu_data = data; lsu_rob = rob;
    @(negedge clk);
    lsu_req_vld = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(sb.size() == 0 && mq.size() == 0 && lsu_req_rdy) && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) begin checks++; $display("FAIL done_timeout: sb %0d mq %0d required 0", sb.size(), mq.size()); end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    main_rst_n = 1'b0; main_flush = 1'b0; lsu_req_vld = 1'b0; lsu_wr = 1'b0;
    lsu_addr = '0; lsu_data = '0; lsu_rob = '0;
    stall_cycles = 0; flush_in_wait = 1'b0; rst_in_wait = 1'b0; rst_done = 1'b0;
    mem_model[32'h1000] = {32'h44, 32'h33, 32'h22, 32'h11};
    #1;
    chk("reset_ctrl_zero", {cmt_vld_o, mem_req_vld_o, lsu_req_rdy, hit_cnt_o, miss_cnt_o}, '0);
    repeat (3) @(negedge clk);
    main_rst_n = 1'b1;
    #1 chk("rdy_after_reset", lsu_req_rdy, 1'b1);

    // Cold load miss, then reload hit
    mq.push_back('{1'b0, 32'h1000, 1'b0, '0});
    issue(1'b0, 32'h1004, 32'h0, 5'd3, 1'b1, 32'h22, 1'b0);
    wait_done();
    chk("miss_after_cold", miss_cnt_o, 32'd1);
    chk("hit_after_cold", hit_cnt_o, 32'd0);
    issue(1'b0, 32'h1004, 32'h0, 5'd4, 1'b1, 32'h22, 1'b1);
    wait_done();
    chk("hit_after_reload", hit_cnt_o, 32'd1);

    // Store hit, then load it back
    issue(1'b1, 32'h1008, 32'hDEAD_BEEF, 5'd5, 1'b1, 32'h0, 1'b1);
    wait_done();
    issue(1'b0, 32'h1008, 32'h0, 5'd6, 1'b1, 32'hDEAD_BEEF, 1'b1);
    wait_done();

    // Fill way1, then evict dirty way0 with writeback, then refetch
    mq.push_back('{1'b0, 32'h2000, 1'b0, '0});
    issue(1'b0, 32'h2000, 32'h0, 5'd7, 1'b1, 32'h2000, 1'b0);
    wait_done();
    mq.push_back('{1'b1, 32'h1000, 1'b1, {32'h44, 32'hDEAD_BEEF, 32'h22, 32'h11}});
    mq.push_back('{1'b0, 32'h3000, 1'b0, '0});
    issue(1'b0, 32'h3000, 32'h0, 5'd8, 1'b1, 32'h3000, 1'b0);
    wait_done();
    mq.push_back('{1'b0, 32'h1000, 1'b0, '0});
    issue(1'b0, 32'h1008, 32'h0, 5'd9, 1'b1, 32'hDEAD_BEEF, 1'b0);
    wait_done();
    chk("miss_after_evict", miss_cnt_o, 32'd4);
    chk("hit_after_evict", hit_cnt_o, 32'd3);

    // Memory back-pressure during FILL_REQ
    stall_cycles = 5;
    mq.push_back('{1'b0, 32'h5010, 1'b0, '0});
    issue(1'b0, 32'h5010, 32'h0, 5'd10, 1'b1, 32'h5010, 1'b0);
    wait_done();
    stall_cycles = 0;

    // Flush in FILL_WAIT squashes the completion but still installs the line
    flush_in_wait = 1'b1;
    mq.push_back('{1'b0, 32'h4000, 1'b0, '0});
    issue(1'b0, 32'h4000, 32'h0, 5'd11, 1'b0, 32'h0, 1'b0);
    wait_done();
    flush_in_wait = 1'b0;
    issue(1'b0, 32'h4000, 32'h0, 5'd12, 1'b1, 32'h4000, 1'b1);
    wait_done();
    chk("hit_after_flush", hit_cnt_o, 32'd4);
    chk("miss_after_flush", miss_cnt_o, 32'd6);

    // Async reset in FILL_WAIT; late response must be ignored
    rst_in_wait = 1'b1;
    mq.push_back('{1'b0, 32'h6000, 1'b0, '0});
    issue(1'b0, 32'h6000, 32'h0, 5'd13, 1'b0, 32'h0, 1'b0);
    begin
      int n = 0;
      while (!rst_done && n < 300) begin @(negedge clk); n++; end
      if (n >= 300) begin checks++; $display("FAIL reset_seq_timeout: rst_done got 0 required 1"); end
    end
    rst_in_wait = 1'b0;
    #1;
    chk("cnt_zero_after_reset", {hit_cnt_o, miss_cnt_o}, '0);
    chk("idle_after_late_resp", {lsu_req_rdy, mem_req_vld_o, cmt_vld_o}, 3'b100);
    mq.push_back('{1'b0, 32'h1000, 1'b0, '0});
    issue(1'b0, 32'h1004, 32'h0, 5'd14, 1'b1, 32'h22, 1'b0);
    wait_done();
    chk("miss_after_reset", miss_cnt_o, 32'd1);
    chk("hit_after_reset", hit_cnt_o, 32'd0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
